// File: rtl/timer_bank.sv
// timer_bank: N_CH-channel interval timer for the MMIO bridge.
// Each channel is a down-counter with one-shot or auto-reload mode and a sticky W1C pending flag.
module timer_bank #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:2]     Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  output logic            IRQ,
  output logic [N_CH-1:0] irq_vec
);

  localparam int CH_AW = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CNT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] R_CTRL = 2'd0;
  localparam logic [1:0] R_PRE  = 2'd1;
  localparam logic [1:0] R_CNT  = 2'd2;
  localparam logic [1:0] R_STAT = 2'd3;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CH_AW-1:0] a_ch;
  logic [1:0]       a_reg;

  assign a_ch  = Addr[CH_AW+3:4];
  assign a_reg = Addr[3:2];

  logic [N_CH-1:0]  en_q;
  logic [N_CH-1:0]  im_q;
  logic [N_CH-1:0]  pend_q;
  logic [1:0]       mode_q   [N_CH];
  logic [1:0]       st_q     [N_CH];
  logic [CNT_W-1:0] preset_q [N_CH];
  logic [CNT_W-1:0] count_q  [N_CH];

  logic [N_CH-1:0] hit;
  logic [N_CH-1:0] stall;
  logic [N_CH-1:0] clr;

  // Address bits above the channel field and Din bits above CNT_W are don't-care.
  logic unused_bits;
  assign unused_bits = ^{Addr[31:CH_AW+4], Din};

  // Per-channel write decode; indices >= N_CH never match, so they are dropped.
  always_comb begin
    hit   = '0;
    stall = '0;
    clr   = '0;
    for (int k = 0; k < N_CH; k++) begin
      hit[k]   = WE && (a_ch == CH_AW'(k));
      stall[k] = hit[k] && (a_reg != R_STAT);
      clr[k]   = hit[k] && (a_reg == R_STAT) && Din[0];
    end
  end

  // Register writes and per-channel FSM; a register write freezes that channel's FSM for the cycle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (reset) begin
        en_q[k]     <= 1'b0;
        im_q[k]     <= 1'b0;
        pend_q[k]   <= 1'b0;
        mode_q[k]   <= 2'b00;
        st_q[k]     <= S_IDLE;
        preset_q[k] <= '0;
        count_q[k]  <= '0;
      end else begin
        // Clear first so that an expiry set below overrides it.
        if (clr[k]) pend_q[k] <= 1'b0;
        if (stall[k]) begin
          unique case (1'b1)
            a_reg == R_CTRL: begin
              en_q[k]   <= Din[0];
              mode_q[k] <= Din[2:1];
              im_q[k]   <= Din[3];
            end
            a_reg == R_PRE: preset_q[k] <= Din[CNT_W-1:0];
            a_reg == R_CNT: count_q[k]  <= Din[CNT_W-1:0];
            default: ;
          endcase
        end else begin
          unique case (st_q[k])
            S_IDLE: if (en_q[k]) st_q[k] <= S_LOAD;
            S_LOAD: begin
              count_q[k] <= preset_q[k];
              st_q[k]    <= S_CNT;
            end
            S_CNT: begin
              if (!en_q[k]) begin
                st_q[k] <= S_IDLE;
              end else if (count_q[k] > ONE) begin
                count_q[k] <= count_q[k] - ONE;
              end else begin
                count_q[k] <= '0;
                pend_q[k]  <= 1'b1;
                st_q[k]    <= S_DONE;
              end
            end
            default: begin
              if (mode_q[k] == 2'b01) begin
                if (en_q[k]) begin
                  count_q[k] <= preset_q[k];
                  st_q[k]    <= S_CNT;
                end else begin
                  st_q[k] <= S_IDLE;
                end
              end else begin
                en_q[k] <= 1'b0;
                st_q[k] <= S_IDLE;
              end
            end
          endcase
        end
      end
    end
  end

  // Combinational read mux; unmatched channel indices read 0.
  always_comb begin
    Dout = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (a_ch == CH_AW'(k)) begin
        unique case (a_reg)
          R_CTRL:  Dout = {28'd0, im_q[k], mode_q[k], en_q[k]};
          R_PRE:   Dout = 32'(preset_q[k]);
          R_CNT:   Dout = 32'(count_q[k]);
          default: Dout = {31'd0, pend_q[k]};
        endcase
      end
    end
  end

  // Interrupt outputs come straight from registered PEND and IM.
  always_comb begin
    irq_vec = pend_q & im_q;
    IRQ     = |irq_vec;
  end

endmodule
